piso_serializer: RTL and testbench

- Parallel-in serial-out converter: the transmit end for the team's 4-bit parallel load registers.
- Accepts a WIDTH-bit word on a load/ready handshake and shifts it out one bit per clock, with valid and last-bit framing.
- Feeds serial links and the team's SIPO receivers.
- Back-to-back words stream with no idle gap.

---
 rtl/shift_reg_pkg.sv | 18 +
 rtl/shift_core.sv | 36 +++
 rtl/piso_serializer.sv | 157 +++++++++++++++
 tb/tb_piso_serializer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the team's shift-register family
// (PISO, SIPO and PIPO blocks).
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  // Index of the bit that leaves the register first.
  function automatic int first_bit_idx(input bit msb_first, input int width);
    return msb_first ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/shift_core.sv
// WIDTH-bit register with parallel load and a one-position shift in either
// direction; vacated positions fill with 0. Load has priority over shift.
module shift_core
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic             dir_left,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_q
);

  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = dir_left ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with load/ready handshake and valid/last
// framing. Define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  output logic             ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int FIRST = first_bit_idx(MSB_FIRST, WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             load_en, shift_en;
  logic             accept;
  logic             next_is_last;
  logic [WIDTH-1:0] shreg_q;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign accept       = load && ready_q;
  assign next_is_last = ((cnt_q + CNT_W'(1)) == LAST_CNT);

  shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .clear    (clear),
    .load_en  (load_en),
    .shift_en (shift_en),
    .dir_left (MSB_FIRST),
    .load_data(p_in),
    .data_q   (shreg_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    last_d   = last_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == LAST_CNT) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
          ready_d = 1'b1;
          last_d  = 1'b1;
`else
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef PISO_PARITY_EN
          ready_d = 1'b0;
          last_d  = 1'b0;
`else
          ready_d = next_is_last;
          last_d  = next_is_last;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
`endif
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    // Accept is only possible on the final cycle of a frame or in IDLE, so it
    // overrides the end-of-frame decision to give a gap-free reload.
    if (accept) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      load_en  = 1'b1;
      shift_en = 1'b0;
      ready_d  = 1'b0;
      valid_d  = 1'b1;
      last_d   = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d = ^p_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    s_out = 1'b0;
    case (state_q)
      SHIFT:   s_out = shreg_q[FIRST];
`ifdef PISO_PARITY_EN
      PARITY:  s_out = parity_q;
`endif
      default: s_out = 1'b0;
    endcase
  end

  assign ready   = ready_q;
  assign s_valid = valid_q;
  assign s_last  = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a queue-based frame model.
module tb_piso_serializer;

  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = WIDTH + (PAR ? 1 : 0);

  typedef struct {
    logic b;
    logic last;
  } ent_t;

  logic             clk   = 1'b0;
  logic             clear = 1'b0;
  logic             load  = 1'b0;
  logic [WIDTH-1:0] p_in  = '0;

  logic m_ready, m_s_out, m_s_valid, m_s_last;
  logic l_ready, l_s_out, l_s_valid, l_s_last;

  int tests_run = 0;
  int fails     = 0;

  ent_t qm[$];
  ent_t ql[$];
  bit   cap_m[$];
  bit   cap_l[$];
  bit   cap_last[$];
  bit   model_acc;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clear(clear), .load(load), .p_in(p_in),
    .ready(m_ready), .s_out(m_s_out), .s_valid(m_s_valid), .s_last(m_s_last)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clear(clear), .load(load), .p_in(p_in),
    .ready(l_ready), .s_out(l_s_out), .s_valid(l_s_valid), .s_last(l_s_last)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A frame is the word's bits in transmit order, plus the parity bit if enabled.
  task automatic push_frame(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) begin
      qm.push_back('{w[WIDTH-1-i], (!PAR && i == WIDTH-1)});
      ql.push_back('{w[i], (!PAR && i == WIDTH-1)});
    end
    if (PAR) begin
      qm.push_back('{^w, 1'b1});
      ql.push_back('{^w, 1'b1});
    end
  endtask

  // The serializer can take a word whenever at most the final bit remains.
  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      qm.delete();
      ql.delete();
    end else begin
      model_acc = load && (qm.size() <= 1);
      if (qm.size() > 0) begin
        qm.delete(0);
        ql.delete(0);
      end
      if (model_acc) push_frame(p_in);
    end
  end

  always @(negedge clk) begin
    check_output("ready_msb", m_ready, qm.size() <= 1);
    check_output("valid_msb", m_s_valid, qm.size() > 0);
    check_output("ready_lsb", l_ready, ql.size() <= 1);
    check_output("valid_lsb", l_s_valid, ql.size() > 0);
    if (qm.size() > 0) begin
      check_output("s_out_msb", m_s_out, qm[0].b);
      check_output("s_last_msb", m_s_last, qm[0].last);
      check_output("s_out_lsb", l_s_out, ql[0].b);
      check_output("s_last_lsb", l_s_last, ql[0].last);
    end
    if (m_s_valid) begin
      cap_m.push_back(m_s_out);
      cap_last.push_back(m_s_last);
    end
    if (l_s_valid) cap_l.push_back(l_s_out);
  end

  task automatic clear_caps();
    @(posedge clk);
    #1;
    cap_m.delete();
    cap_l.delete();
    cap_last.delete();
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] w);
    @(negedge clk);
    load = 1'b1;
    p_in = w;
    @(negedge clk);
    load = 1'b0;
    p_in = '0;
  endtask

  // Captured bits are packed first-bit-in-MSB and compared with literals.
  task automatic check_seq(input string name, input int n, input logic [15:0] em,
                           input logic [15:0] el, input logic [15:0] elast);
    logic [15:0] vm, vl, vla;
    vm = '0;
    vl = '0;
    vla = '0;
    foreach (cap_m[i]) vm = {vm[14:0], cap_m[i]};
    foreach (cap_l[i]) vl = {vl[14:0], cap_l[i]};
    foreach (cap_last[i]) vla = {vla[14:0], cap_last[i]};
    check_output({name, "_len"}, cap_m.size(), n);
    check_output({name, "_msb_bits"}, vm, em);
    check_output({name, "_lsb_bits"}, vl, el);
    check_output({name, "_last"}, vla, elast);
  endtask

  initial begin
    clear = 1'b0;
    load  = 1'b1;
    p_in  = 4'b1011;
    #12;
    check_output("rst_ready", m_ready, 1);
    check_output("rst_valid", m_s_valid, 0);
    check_output("rst_s_out", m_s_out, 0);
    check_output("rst_s_last", m_s_last, 0);
    @(negedge clk);
    load  = 1'b0;
    p_in  = '0;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_no_accept", m_s_valid, 0);

    clear_caps();
    apply_stimulus(4'b1011);
    repeat (FRAME + 2) @(negedge clk);
    check_seq("single", FRAME,
              PAR ? 16'b10111 : 16'b1011,
              PAR ? 16'b11011 : 16'b1101,
              PAR ? 16'b00001 : 16'b0001);

    clear_caps();
    @(negedge clk);
    load = 1'b1;
    p_in = 4'b1011;
    @(negedge clk);
    p_in = 4'b0110;
    repeat (FRAME) @(negedge clk);
    load = 1'b0;
    p_in = '0;
    repeat (FRAME + 2) @(negedge clk);
    check_seq("b2b", 2 * FRAME,
              PAR ? 16'b1011101100 : 16'b10110110,
              PAR ? 16'b1101101100 : 16'b11010110,
              PAR ? 16'b0000100001 : 16'b00010001);

    apply_stimulus(4'b1011);
    @(posedge clk);
    #2;
    clear = 1'b0;
    #1;
    check_output("midrst_valid_msb", m_s_valid, 0);
    check_output("midrst_ready_msb", m_ready, 1);
    check_output("midrst_valid_lsb", l_s_valid, 0);
    check_output("midrst_ready_lsb", l_ready, 1);
    check_output("midrst_last", m_s_last, 0);
    @(negedge clk);
    clear = 1'b1;
    clear_caps();
    apply_stimulus(4'b0001);
    repeat (FRAME + 2) @(negedge clk);
    check_seq("after_rst", FRAME,
              PAR ? 16'b00011 : 16'b0001,
              PAR ? 16'b10001 : 16'b1000,
              PAR ? 16'b00001 : 16'b0001);

    clear_caps();
    apply_stimulus(4'b1100);
    load = 1'b1;
    p_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    p_in = '0;
    repeat (FRAME + 2) @(negedge clk);
    check_seq("drop_busy", FRAME,
              PAR ? 16'b11000 : 16'b1100,
              PAR ? 16'b00110 : 16'b0011,
              PAR ? 16'b00001 : 16'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
